gesture_power_sequencer: RTL and testbench

//  Two-gesture power on/off sequencer for the range hood.

---
 rtl/gesture_power_sequencer.sv | 116 +++++++++++
 tb/tb_gesture_power_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gesture_power_sequencer.sv
// rtl/gesture_power_sequencer.sv - two-gesture hood power on/off sequencer with timed window
// Optional sticky timeout_flag output is enabled by defining GESTURE_TIMEOUT_FLAG_EN.
module gesture_power_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gesture_left,
  input  logic             gesture_right,
  input  logic [CNT_W-1:0] window_ticks,
  output logic             power_on,
  output logic [1:0]       state,
  output logic             window_active,
  output logic [CNT_W-1:0] window_remaining,
  output logic             timeout_pulse
`ifdef GESTURE_TIMEOUT_FLAG_EN
  ,
  output logic             timeout_flag
`endif
);

  typedef enum logic [1:0] {
    S_OFF     = 2'b00,
    S_ARM_ON  = 2'b01,
    S_ON      = 2'b10,
    S_ARM_OFF = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           st;
  logic             left_q;
  logic             right_q;
  logic [CNT_W-1:0] cnt;

  logic             rise_l;
  logic             rise_r;
  logic             expire;
  logic             completes;
  logic [CNT_W-1:0] arm_ticks;

  // Simultaneous rises cancel each other, so each rise_* is "this side only".
  always_comb begin
    rise_l    = gesture_left & ~left_q & ~(gesture_right & ~right_q);
    rise_r    = gesture_right & ~right_q & ~(gesture_left & ~left_q);
    arm_ticks = (window_ticks == '0) ? ONE : window_ticks;
    expire    = ((st == S_ARM_ON) || (st == S_ARM_OFF)) && (cnt == '0);
    completes = (cnt != '0) &&
                (((st == S_ARM_ON) && rise_r) || ((st == S_ARM_OFF) && rise_l));
  end

  assign state            = st;
  assign window_remaining = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st            <= S_OFF;
      left_q        <= 1'b0;
      right_q       <= 1'b0;
      cnt           <= '0;
      power_on      <= 1'b0;
      window_active <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      left_q        <= gesture_left;
      right_q       <= gesture_right;
      timeout_pulse <= 1'b0;
      case (st)
        S_OFF: begin
          if (rise_l) begin
            st            <= S_ARM_ON;
            cnt           <= arm_ticks;
            window_active <= 1'b1;
          end
        end
        S_ON: begin
          if (rise_r) begin
            st            <= S_ARM_OFF;
            cnt           <= arm_ticks;
            window_active <= 1'b1;
          end
        end
        S_ARM_ON, S_ARM_OFF: begin
          // Expiry has priority, so an edge arriving with cnt==0 is dropped.
          if (expire) begin
            st            <= (st == S_ARM_ON) ? S_OFF : S_ON;
            timeout_pulse <= 1'b1;
            window_active <= 1'b0;
          end else if (completes) begin
            st            <= (st == S_ARM_ON) ? S_ON : S_OFF;
            power_on      <= (st == S_ARM_ON);
            cnt           <= '0;
            window_active <= 1'b0;
          end else if ((st == S_ARM_ON) ? rise_l : rise_r) begin
            cnt <= arm_ticks;
          end else begin
            cnt <= cnt - ONE;
          end
        end
      endcase
    end
  end

`ifdef GESTURE_TIMEOUT_FLAG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_flag <= 1'b0;
    end else if (completes) begin
      timeout_flag <= 1'b0;
    end else if (expire) begin
      timeout_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gesture_power_sequencer.sv
// tb/tb_gesture_power_sequencer.sv - scoreboard bench for gesture_power_sequencer
// Directed window scenarios plus randomized gestures against a window/power model.
module tb_gesture_power_sequencer;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             gesture_left = 1'b0;
  logic             gesture_right = 1'b0;
  logic [CNT_W-1:0] window_ticks = '0;
  logic             power_on;
  logic [1:0]       state;
  logic             window_active;
  logic [CNT_W-1:0] window_remaining;
  logic             timeout_pulse;
`ifdef GESTURE_TIMEOUT_FLAG_EN
  logic             timeout_flag;
`endif

  gesture_power_sequencer #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .gesture_left     (gesture_left),
    .gesture_right    (gesture_right),
    .window_ticks     (window_ticks),
    .power_on         (power_on),
    .state            (state),
    .window_active    (window_active),
    .window_remaining (window_remaining),
    .timeout_pulse    (timeout_pulse)
`ifdef GESTURE_TIMEOUT_FLAG_EN
    ,
    .timeout_flag     (timeout_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pwr;
    logic [1:0]  st;
    logic        wa;
    logic [31:0] rem;
    logic        pulse;
    logic        flag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: hood power bit plus an optional open window with remaining ticks.
  bit          m_pwr, m_arm, m_pulse, m_flag, m_pl, m_pr;
  int unsigned m_rem;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pwr = 0; m_arm = 0; m_pulse = 0; m_flag = 0; m_pl = 0; m_pr = 0; m_rem = 0;
  endtask

  task automatic model_step();
    bit rl, rr;
    int unsigned span;
    exp_t e;
    rl = gesture_left && !m_pl;
    rr = gesture_right && !m_pr;
    m_pl = gesture_left;
    m_pr = gesture_right;
    if (rl && rr) begin
      rl = 0;
      rr = 0;
    end
    span = (window_ticks == 0) ? 1 : window_ticks;
    m_pulse = 0;
    if (!m_arm) begin
      if (m_pwr ? rr : rl) begin
        m_arm = 1;
        m_rem = span;
      end
    end else if (m_rem == 0) begin
      m_arm = 0;
      m_pulse = 1;
      m_flag = 1;
    end else if (m_pwr ? rl : rr) begin
      m_pwr = !m_pwr;
      m_arm = 0;
      m_rem = 0;
      m_flag = 0;
    end else if (m_pwr ? rr : rl) begin
      m_rem = span;
    end else begin
      m_rem = m_rem - 1;
    end
    e.pwr = m_pwr; e.st = {m_pwr, m_arm}; e.wa = m_arm;
    e.rem = m_rem; e.pulse = m_pulse; e.flag = m_flag;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit l, input bit r, input int unsigned wt);
    @(negedge clk);
    gesture_left = l;
    gesture_right = r;
    window_ticks = wt;
    model_step();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic assert_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_state", {30'd0, state}, 0);
    chk("rst_power", {31'd0, power_on}, 0);
    chk("rst_remaining", window_remaining, 0);
    chk("rst_active", {31'd0, window_active}, 0);
    chk("rst_pulse", {31'd0, timeout_pulse}, 0);
    gesture_left = 1'b0;
    gesture_right = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset(input bit l, input int unsigned wt);
    @(negedge clk);
    model_reset();
    gesture_left = l;
    gesture_right = 1'b0;
    window_ticks = wt;
    reset = 1'b1;
    model_step();
  endtask

  // Monitor: every clock after the edge, compare DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("power_on", {31'd0, power_on}, {31'd0, e.pwr});
        chk("state", {30'd0, state}, {30'd0, e.st});
        chk("window_active", {31'd0, window_active}, {31'd0, e.wa});
        chk("window_remaining", window_remaining, e.rem);
        chk("timeout_pulse", {31'd0, timeout_pulse}, {31'd0, e.pulse});
`ifdef GESTURE_TIMEOUT_FLAG_EN
        chk("timeout_flag", {31'd0, timeout_flag}, {31'd0, e.flag});
`endif
      end
    end
  end

  initial begin
    bit l, r;
    int unsigned wt;
    model_reset();
    assert_reset();
    release_reset(0, 10);

    // Left then nothing: window counts 10..0, expires on cycle 11.
    step(1, 0, 10);
    for (int i = 1; i <= 11; i++) step(0, 0, 10);
    settle();
    chk("t3_pulse", {31'd0, timeout_pulse}, 1);
    chk("t3_state", {30'd0, state}, 0);
`ifdef GESTURE_TIMEOUT_FLAG_EN
    chk("t3_flag", {31'd0, timeout_flag}, 1);
`endif

    // Left then right four cycles later: power on.
    step(1, 0, 10);
    for (int i = 1; i <= 3; i++) step(0, 0, 10);
    step(0, 1, 10);
    settle();
    chk("t2_state", {30'd0, state}, 2);
    chk("t2_power", {31'd0, power_on}, 1);
    chk("t2_pulse", {31'd0, timeout_pulse}, 0);
`ifdef GESTURE_TIMEOUT_FLAG_EN
    chk("t2_flag", {31'd0, timeout_flag}, 0);
`endif

    // Right then left exactly on the expiry cycle: rejected, stays on.
    step(0, 0, 3);
    step(0, 1, 3);
    for (int i = 1; i <= 3; i++) step(0, 0, 3);
    step(1, 0, 3);
    settle();
    chk("t4_pulse", {31'd0, timeout_pulse}, 1);
    chk("t4_state", {30'd0, state}, 2);
    chk("t4_power", {31'd0, power_on}, 1);

    // Power off, then window_ticks=0 behaves as one cycle, then simultaneous rises.
    step(0, 1, 5);
    step(1, 0, 5);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    settle();
    chk("t5_zero_window_on", {30'd0, state}, 2);
    step(0, 0, 5);
    step(0, 1, 5);
    step(1, 0, 5);
    step(0, 0, 5);
    step(1, 1, 5);
    settle();
    chk("t5_both_off", {30'd0, state}, 0);

    // Reset in the middle of an ARM_ON window with five ticks left.
    step(0, 0, 9);
    step(1, 0, 9);
    for (int i = 1; i <= 4; i++) step(0, 0, 9);
    settle();
    chk("t1_pre_remaining", window_remaining, 5);
    assert_reset();

    // Left already high at release counts as a rising edge.
    release_reset(1, 6);
    settle();
    chk("rel_edge_state", {30'd0, state}, 1);

    l = 1;
    r = 0;
    wt = 6;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) l = !l;
      if ($urandom_range(0, 3) == 0) r = !r;
      if ($urandom_range(0, 15) == 0) wt = $urandom_range(0, 12);
      step(l, r, wt);
    end
    step(0, 0, wt);
    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
